// File: rtl/shift_sequencer_if.sv
// Request/response bundle for the multi-cycle shift sequencer.
// The master is the request producer and result consumer; the slave is the sequencer.
interface shift_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_x;
  logic [31:0]      in_y;
  logic [1:0]       in_op;
  logic             flush;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_z;

  modport master (
    output in_valid, in_x, in_y, in_op, flush, out_ready,
    input  in_ready, busy, out_valid, out_z
  );

  modport slave (
    input  in_valid, in_x, in_y, in_op, flush, out_ready,
    output in_ready, busy, out_valid, out_z
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle SLL/SRL/SRA/ROR sequencer: steps the operand one bit per clock,
// then presents the result on a valid/ready handshake until it is taken.
module shift_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic             clk,
  input logic             rstb,
  shift_sequencer_if.slave bus
);
  localparam int LW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  logic [1:0]       state;
  logic [1:0]       op;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] z_q;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] n_eff;

  // Full 32-bit compare before clamping, so large amounts never alias small ones.
  always_comb begin
    n_eff = '0;
    if (bus.in_op == OP_ROR)
      n_eff = CNT_W'(bus.in_y[LW-1:0]);
    else if (bus.in_y >= 32'(WIDTH))
      n_eff = CNT_W'(WIDTH);
    else
      n_eff = CNT_W'(bus.in_y);
  end

  always_comb begin
    step = data;
    case (op)
      OP_SLL:  step = {data[WIDTH-2:0], 1'b0};
      OP_SRL:  step = {1'b0, data[WIDTH-1:1]};
      OP_SRA:  step = {data[WIDTH-1], data[WIDTH-1:1]};
      OP_ROR:  step = {data[0], data[WIDTH-1:1]};
      default: step = data;
    endcase
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.busy      = (state != S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.out_z     = z_q;

  // The result register only loads on entry to DONE, so out_z holds the last
  // result while the next operand is being stepped in data.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state <= S_IDLE;
      op    <= '0;
      data  <= '0;
      count <= '0;
      z_q   <= '0;
    end else if (bus.flush) begin
      state <= S_IDLE;
      count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            data  <= bus.in_x;
            op    <= bus.in_op;
            count <= n_eff;
            if (n_eff == '0) begin
              state <= S_DONE;
              z_q   <= bus.in_x;
            end else begin
              state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          data  <= step;
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            state <= S_DONE;
            z_q   <= step;
          end
        end
        S_DONE: begin
          if (bus.out_ready)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
